// File: rtl/bus_move_ctrl_pkg.sv
// bus_move_ctrl_pkg: shared defaults and FSM state encoding for the MicroCPU bus move controller.
`default_nettype none

package bus_move_ctrl_pkg;

  localparam int NUM_UNITS_DEF = 8;
  localparam int BUS_LEN_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    CAPT  = 3'd2,
    TURN  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // Both strobe states keep the source on the bus.
  function automatic logic is_strobe_state(input state_e s);
    return (s == DRIVE) || (s == CAPT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_move_ctrl_sel_dec.sv
// bus_sel_dec: index to one-hot decoder with enable; out-of-range indices decode to all-zero.
`default_nettype none

module bus_sel_dec #(
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = 4
) (
  input  logic               en_i,
  input  logic [SEL_W-1:0]   idx_i,
  output logic [NUM_OUT-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (en_i && (idx_i == SEL_W'(i))) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_move_ctrl.sv
// bus_move_ctrl: single-transfer initiator sequencing drive/capture strobes on the shared data bus.
// Optional immediate source (code NUM_UNITS) compiled in with BUS_MOVE_IMM_EN.
`default_nettype none

module bus_move_ctrl
  import bus_move_ctrl_pkg::*;
#(
  parameter int NUM_UNITS = NUM_UNITS_DEF,
  parameter int BUS_LEN   = BUS_LEN_DEF,
  parameter int SEL_W     = $clog2(NUM_UNITS + 1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SEL_W-1:0]     req_src,
  input  logic [SEL_W-1:0]     req_dst,
`ifdef BUS_MOVE_IMM_EN
  input  logic [BUS_LEN-1:0]   req_imm,
  inout  wire  [BUS_LEN-1:0]   bus,
`else
  input  logic [BUS_LEN-1:0]   bus,
`endif
  output logic [NUM_UNITS-1:0] wr_en,
  output logic [NUM_UNITS-1:0] rd_en,
  output logic [BUS_LEN-1:0]   xfer_data,
  output logic                 done,
  output logic                 err
);

  localparam logic [SEL_W-1:0] IMM_CODE = SEL_W'(NUM_UNITS);
`ifdef BUS_MOVE_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     src_q, src_d;
  logic [SEL_W-1:0]     dst_q, dst_d;
  logic [NUM_UNITS-1:0] wr_en_d, rd_en_d;
  logic                 accept, legal, strobe_d;

  always_comb begin
    accept   = req_valid && req_ready;
    legal    = (req_src != req_dst) && (req_dst < IMM_CODE) &&
               ((req_src < IMM_CODE) || (IMM_EN && (req_src == IMM_CODE)));
    src_d    = accept ? req_src : src_q;
    dst_d    = accept ? req_dst : dst_q;
    state_d  = state_q;
    case (state_q)
      IDLE, TURN: state_d = accept ? (legal ? DRIVE : ERR) : IDLE;
      DRIVE:      state_d = CAPT;
      CAPT:       state_d = TURN;
      ERR:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    strobe_d = is_strobe_state(state_d);
  end

  // The immediate code is out of decoder range, so it never raises a wr_en bit.
  bus_sel_dec #(.NUM_OUT(NUM_UNITS), .SEL_W(SEL_W)) u_wr_dec (
    .en_i     (strobe_d),
    .idx_i    (src_d),
    .onehot_o (wr_en_d)
  );

  bus_sel_dec #(.NUM_OUT(NUM_UNITS), .SEL_W(SEL_W)) u_rd_dec (
    .en_i     (state_d == CAPT),
    .idx_i    (dst_d),
    .onehot_o (rd_en_d)
  );

`ifdef BUS_MOVE_IMM_EN
  logic [BUS_LEN-1:0] imm_q;
  logic               drv_imm_q;
  assign bus = drv_imm_q ? imm_q : {BUS_LEN{1'bz}};
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      wr_en     <= '0;
      rd_en     <= '0;
      xfer_data <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
`ifdef BUS_MOVE_IMM_EN
      imm_q     <= '0;
      drv_imm_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      wr_en     <= wr_en_d;
      rd_en     <= rd_en_d;
      done      <= (state_d == TURN);
      err       <= (state_d == ERR);
      req_ready <= (state_d == IDLE) || (state_d == TURN);
      if (state_q == CAPT) begin
        xfer_data <= bus;
      end
`ifdef BUS_MOVE_IMM_EN
      if (accept) begin
        imm_q <= req_imm;
      end
      drv_imm_q <= strobe_d && (src_d == IMM_CODE);
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_move_ctrl.sv
// tb_bus_move_ctrl: table vectors, directed corner sequences and random traffic against a schedule model.
`default_nettype none

module tb_bus_move_ctrl;

  localparam int N    = 8;
  localparam int W    = 8;
  localparam int SW   = 4;
  localparam int MAXC = 8192;
`ifdef BUS_MOVE_IMM_EN
  localparam bit IMM_OK = 1'b1;
`else
  localparam bit IMM_OK = 1'b0;
`endif
  localparam logic [W-1:0] INIT [N] = '{8'h3C, 8'h5A, 8'hA5, 8'h0F, 8'hC3, 8'h00, 8'h99, 8'h00};

  logic          CLK = 1'b0;
  logic          RESET;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_src, req_dst;
  logic [W-1:0]  req_imm;
  logic [N-1:0]  wr_en, rd_en;
  logic [W-1:0]  xfer_data;
  logic          done, err;
  wire  [W-1:0]  bus;

  always #5 CLK = ~CLK;

  bus_move_ctrl #(.NUM_UNITS(N), .BUS_LEN(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
`ifdef BUS_MOVE_IMM_EN
    .req_imm   (req_imm),
`endif
    .bus       (bus),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .xfer_data (xfer_data),
    .done      (done),
    .err       (err)
  );

  // Bus responders: drive their register while wr_en, capture on rd_en.
  logic [W-1:0] resp [N];
  logic [W-1:0] drv_val;
  logic         drv_any;
  logic         load;

  always_comb begin
    drv_val = '0;
    drv_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (wr_en[i]) begin
        drv_val = drv_val | resp[i];
        drv_any = 1'b1;
      end
    end
  end

`ifdef BUS_MOVE_IMM_EN
  assign bus = drv_any ? drv_val : {W{1'bz}};
`else
  assign bus = drv_val;
`endif

  always @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (load) resp[i] <= INIT[i];
      else if (rd_en[i]) resp[i] <= bus;
    end
  end

  // Reference model: per-cycle expected outputs plus unit contents.
  logic [N-1:0] e_wr [MAXC];
  logic [N-1:0] e_rd [MAXC];
  bit           e_done [MAXC];
  bit           e_err [MAXC];
  bit           e_busy [MAXC];
  logic [W-1:0] mem [N];
  logic [W-1:0] m_xfer;
  bit           pend;
  int           pend_cyc, pend_dst;
  logic [W-1:0] pend_val;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit saw_err, saw_done;
  int done_cnt;
  bit acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int idx);
    logic [N-1:0] r;
    r = '0;
    if (idx < N) r[idx] = 1'b1;
    return r;
  endfunction

  task automatic schedule(input int k, input int s, input int d, input logic [W-1:0] im);
    bit ok;
    ok = (s != d) && (d < N) && ((s < N) || (IMM_OK && s == N));
    acc = 1'b1;
    if (ok) begin
      e_wr[k+1] = oh(s);  e_wr[k+2] = oh(s);  e_rd[k+2] = oh(d);
      e_busy[k+1] = 1'b1; e_busy[k+2] = 1'b1; e_done[k+3] = 1'b1;
      pend = 1'b1; pend_cyc = k + 3; pend_dst = d;
      pend_val = (s == N) ? im : mem[s];
    end else begin
      e_err[k+1]  = 1'b1;
      e_busy[k+1] = 1'b1;
    end
  endtask

  task automatic tick(input bit v, input int s, input int d, input logic [W-1:0] im, input bit rn);
    req_valid = v;
    req_src   = SW'(s);
    req_dst   = SW'(d);
    req_imm   = im;
    RESET     = rn;
    acc       = 1'b0;
    if (rn && v && !e_busy[cyc]) schedule(cyc, s, d, im);
    @(posedge CLK);
    #1;
    cyc++;
    if (!rn) begin
      for (int j = 0; j < 4; j++) begin
        e_wr[cyc+j] = '0; e_rd[cyc+j] = '0;
        e_done[cyc+j] = 1'b0; e_err[cyc+j] = 1'b0; e_busy[cyc+j] = 1'b0;
      end
      // A reset landing on the capture edge still lets the responder capture.
      if (pend && cyc == pend_cyc) mem[pend_dst] = pend_val;
      pend   = 1'b0;
      m_xfer = '0;
    end else if (pend && cyc == pend_cyc) begin
      mem[pend_dst] = pend_val;
      m_xfer        = pend_val;
      pend          = 1'b0;
    end
    check("wr_en", wr_en, e_wr[cyc]);
    check("rd_en", rd_en, e_rd[cyc]);
    check("done", done, e_done[cyc]);
    check("err", err, e_err[cyc]);
    check("req_ready", req_ready, !e_busy[cyc]);
    check("xfer_data", xfer_data, m_xfer);
    check("wr_onehot0", $onehot0(wr_en), 1);
    check("rd_onehot0", $onehot0(rd_en), 1);
`ifndef BUS_MOVE_IMM_EN
    check("rd_without_wr", (rd_en != '0) && (wr_en == '0), 0);
`endif
    if (err) saw_err = 1'b1;
    if (done) begin
      saw_done = 1'b1;
      done_cnt++;
    end
  endtask

  typedef struct {
    int           src;
    int           dst;
    logic [W-1:0] imm;
    bit           exp_err;
    logic [W-1:0] exp_xfer;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{2, 5, 8'h00, 1'b0, 8'hA5};
    tbl[1] = '{4, 4, 8'h00, 1'b1, 8'h00};
    tbl[2] = '{1, 8, 8'h00, 1'b1, 8'h00};
    tbl[3] = '{5, 0, 8'h00, 1'b0, 8'hA5};
    tbl[4] = '{6, 3, 8'h00, 1'b0, 8'h99};
`ifdef BUS_MOVE_IMM_EN
    tbl[5] = '{8, 7, 8'h03, 1'b0, 8'h03};
`else
    tbl[5] = '{8, 7, 8'h03, 1'b1, 8'h00};
`endif
    tbl[6] = '{9, 1, 8'h00, 1'b1, 8'h00};
    tbl[7] = '{0, 7, 8'h00, 1'b0, 8'hA5};

    for (int i = 0; i < N; i++) mem[i] = INIT[i];
    m_xfer = '0;
    pend   = 1'b0;
    load   = 1'b1;
    repeat (3) tick(0, 0, 0, 8'h00, 0);
    load   = 1'b0;
    repeat (2) tick(0, 0, 0, 8'h00, 1);

    for (int i = 0; i < 8; i++) begin
      saw_err  = 1'b0;
      saw_done = 1'b0;
      tick(1, tbl[i].src, tbl[i].dst, tbl[i].imm, 1);
      repeat (4) tick(0, 0, 0, 8'h00, 1);
      check("tbl_err", saw_err, tbl[i].exp_err);
      check("tbl_done", saw_done, !tbl[i].exp_err);
      if (!tbl[i].exp_err) check("tbl_xfer", xfer_data, tbl[i].exp_xfer);
    end
    check("tbl_dst5", resp[5], 8'hA5);

    // Back-to-back: second request held valid until the TURN cycle accepts it.
    done_cnt = 0;
    tick(1, 1, 3, 8'h00, 1);
    for (int t = 0; t < 6; t++) begin
      tick(1, 3, 1, 8'h00, 1);
      if (acc) break;
    end
    repeat (5) tick(0, 0, 0, 8'h00, 1);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_dst3", resp[3], 8'h5A);
    check("b2b_dst1", resp[1], 8'h5A);

    // Reset while in DRIVE: destination untouched, no done.
    saw_done = 1'b0;
    tick(1, 2, 6, 8'h00, 1);
    tick(0, 0, 0, 8'h00, 0);
    check("rst_wr", wr_en, 0);
    check("rst_ready", req_ready, 1);
    repeat (4) tick(0, 0, 0, 8'h00, 1);
    check("rst_dst6", resp[6], 8'h99);
    check("rst_no_done", saw_done, 0);

    // Request fields changed while busy must not disturb the transfer.
    tick(1, 0, 4, 8'h00, 1);
    tick(1, 5, 2, 8'h00, 1);
    tick(1, 7, 1, 8'h00, 1);
    repeat (5) tick(0, 0, 0, 8'h00, 1);
    check("hold_dst4", resp[4], 8'hA5);
    check("hold_dst1", resp[1], 8'h5A);
    check("hold_xfer", xfer_data, 8'hA5);

    for (int t = 0; t < 1500; t++) begin
      int s, d;
      s = (($urandom % 8) == 0) ? int'($urandom % 16) : int'($urandom % 10);
      d = (($urandom % 8) == 0) ? int'($urandom % 16) : int'($urandom % 9);
      tick(($urandom % 3) != 0, s, d, W'($urandom), ($urandom % 60) != 0);
    end
    repeat (6) tick(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < N; i++) check("final_unit", resp[i], mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
